// File: rtl/sm_hex_display.sv
// sm_hex_display: multiplexed common-anode hex display scanner with per-frame input snapshot
module sm_hex_display #(
  parameter int DIGITS  = 8,
  parameter int REFRESH = 16,
  parameter int GUARD   = 4
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  blankLeading,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dpIn,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [REFRESH-1:0] G = REFRESH'(GUARD);
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [REFRESH-1:0]  cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_d;
  logic [DIGITS-1:0]   snap_p;
  logic                tick, last, upper_zero, lead_zero, blank;
  logic [3:0]          nib;
  assign tick  = &cnt;
  assign last  = idx == IW'(DIGITS - 1);
  assign nib   = snap_d[{idx, 2'b00} +: 4];
  assign blank = cnt < G || (blankLeading && idx != '0 && lead_zero);
  // walk nibbles from the top down; lead_zero is set when idx and everything above it is zero
  always_comb begin
    upper_zero = 1'b1;
    lead_zero  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (snap_d[4*i +: 4] == 4'h0);
      if (IW'(i) == idx) lead_zero = upper_zero;
    end
  end
  // prescaler, digit index and end-of-frame snapshot; all frozen while disabled
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      snap_d <= '0;
      snap_p <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;
      if (tick && last) begin
        snap_d <= data;
        snap_p <= dpIn;
      end
    end
  end
  // registered digit drive; dark during guard, leading-zero blanking, or when disabled
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      anode <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      anode <= (!enable || blank) ? '1 : ~(DIGITS'(1) << idx);
      seg   <= (!enable || blank) ? 7'h7F : HEX[nib];
      dp    <= (!enable || blank) ? 1'b1 : ~snap_p[idx];
    end
  end
endmodule

// File: tb/tb_sm_hex_display.sv
// tb_sm_hex_display: directed checks of scan order, snapshot, blanking, dp, enable and encoding
module tb_sm_hex_display;
  logic        clkIn = 1'b0;
  logic        rst_n, enable, blankLeading;
  logic [15:0] data;
  logic [3:0]  dpIn;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  data1;
  logic        dpIn1;
  logic        anode1;
  logic [6:0]  seg1;
  logic        dp1;
  int          vectors = 0;
  int          miscompares = 0;
  int          pos = 0;
  logic [6:0]  hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  sm_hex_display #(.DIGITS(4), .REFRESH(2), .GUARD(1)) u0 (
    .clkIn(clkIn), .rst_n(rst_n), .enable(enable), .blankLeading(blankLeading),
    .data(data), .dpIn(dpIn), .anode(anode), .seg(seg), .dp(dp)
  );

  sm_hex_display #(.DIGITS(1), .REFRESH(2), .GUARD(0)) u1 (
    .clkIn(clkIn), .rst_n(rst_n), .enable(enable), .blankLeading(blankLeading),
    .data(data1), .dpIn(dpIn1), .anode(anode1), .seg(seg1), .dp(dp1)
  );

  always #5 clkIn = ~clkIn;

  // expected {anode,seg,dp} for the enabled edge number pos since reset
  function automatic logic [11:0] expect_out(input logic [15:0] v, input logic [3:0] mask,
                                             input logic [3:0] dpv);
    int ph, d;
    ph = (pos - 1) % 4;
    d  = ((pos - 1) / 4) % 4;
    if (ph == 0 || !mask[d]) return {4'hF, 7'h7F, 1'b1};
    return {~(4'b0001 << d), hex_tab[v[4*d +: 4]], ~dpv[d]};
  endfunction

  task automatic run_clocks(input int n, input logic [15:0] v, input logic [3:0] mask,
                            input logic [3:0] dpv, input string name);
    logic [11:0] exp_o;
    for (int i = 0; i < n; i++) begin
      @(posedge clkIn); #1;
      pos++;
      exp_o = expect_out(v, mask, dpv);
      vectors++;
      if ({anode, seg, dp} !== exp_o) begin
        miscompares++;
        $display("FAIL %s pos=%0d: got anode=%h seg=%h dp=%b, want anode=%h seg=%h dp=%b",
                 name, pos, anode, seg, dp, exp_o[11:8], exp_o[7:1], exp_o[0]);
      end
    end
  endtask

  task automatic check_dark(input string name);
    vectors++;
    if ({anode, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      miscompares++;
      $display("FAIL %s: got anode=%h seg=%h dp=%b, want anode=f seg=7f dp=1", name, anode, seg, dp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; blankLeading = 1'b0;
    data = 16'h1234; dpIn = 4'h0; data1 = 4'h0; dpIn1 = 1'b0;
    #12;
    check_dark("reset_hold");
    @(negedge clkIn) rst_n = 1'b1;
    pos = 0;
    run_clocks(5, 16'h0000, 4'hF, 4'h0, "pre_reset_scan");
    #2 rst_n = 1'b0;
    #1 check_dark("reset_midscan");
    @(negedge clkIn) rst_n = 1'b1;
    pos = 0;
    run_clocks(16, 16'h0000, 4'hF, 4'h0, "restart_frame0");
  endtask

  task automatic test_scan_order;
    run_clocks(16, 16'h1234, 4'hF, 4'h0, "scan_1234_a");
    run_clocks(16, 16'h1234, 4'hF, 4'h0, "scan_1234_b");
  endtask

  task automatic test_no_tearing;
    run_clocks(6, 16'h1234, 4'hF, 4'h0, "tear_before");
    data = 16'hABCD;
    run_clocks(10, 16'h1234, 4'hF, 4'h0, "tear_rest");
    run_clocks(16, 16'hABCD, 4'hF, 4'h0, "tear_next");
  endtask

  task automatic test_leading_blank;
    blankLeading = 1'b1;
    data = 16'h0120;
    run_clocks(16, 16'hABCD, 4'hF, 4'h0, "lead_abcd");
    data = 16'h0000;
    run_clocks(16, 16'h0120, 4'b0111, 4'h0, "lead_0120");
    run_clocks(16, 16'h0000, 4'b0001, 4'h0, "lead_zero");
  endtask

  task automatic test_dp_enable;
    blankLeading = 1'b0;
    data = 16'h1234;
    dpIn = 4'b0100;
    run_clocks(16, 16'h0000, 4'hF, 4'h0, "dp_prev_frame");
    run_clocks(6, 16'h1234, 4'hF, 4'b0100, "dp_before_hold");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clkIn); #1;
      check_dark("enable_low");
    end
    enable = 1'b1;
    run_clocks(10, 16'h1234, 4'hF, 4'b0100, "dp_resume");
  endtask

  task automatic test_sweep;
    dpIn1 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      data1 = 4'(v);
      repeat (4) @(posedge clkIn);
      for (int c = 0; c < 4; c++) begin
        @(posedge clkIn); #1;
        vectors++;
        if ({anode1, seg1, dp1} !== {1'b0, hex_tab[v], 1'b0}) begin
          miscompares++;
          $display("FAIL sweep v=%h: got anode=%b seg=%h dp=%b, want anode=0 seg=%h dp=0",
                   v, anode1, seg1, dp1, hex_tab[v]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan_order;
    test_no_tearing;
    test_leading_blank;
    test_dp_enable;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
